// File: rtl/ndro_pkg.sv
// Shared types for the NDRO pulse sequencer: command encoding, FSM states and the pulse bundle.
// No logic of its own; op_pulse maps a command onto the single pulse line it drives.
package ndro_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_READ  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GUARD = 2'b10
  } state_e;

  typedef struct packed {
    logic set;
    logic reset;
    logic clk;
  } pulse_t;

  function automatic pulse_t op_pulse(input cmd_op_e op);
    pulse_t p;
    p = '0;
    case (op)
      OP_SET:   p.set   = 1'b1;
      OP_RESET: p.reset = 1'b1;
      OP_READ:  p.clk   = 1'b1;
      default:  ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ndro_pulse_timer.sv
// Loadable down-counter; expire is high in the last cycle of a loaded interval (count == 1).
// Latency: load at edge k with value N -> expire high in cycle k+N-1; no backpressure, load wins.
module ndro_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/ndro_pulse_sequencer.sv
// Drives set/reset/clk pulses into a basic NDRO cell, tracks its expected bit and checks reads.
// Pulse at accept edge, then a forced guard gap; cmd_ready is low outside IDLE and ops are never queued.
module ndro_pulse_sequencer
  import ndro_pkg::*;
#(
  parameter int PULSE_W  = 1,
  parameter int GUARD    = 4,
  parameter int READ_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       set_o,
  output logic       reset_o,
  output logic       clk_o,
  input  logic       ndro_out_i,
  output logic       rd_valid,
  output logic       rd_data,
  output logic       rd_expect,
  output logic       mismatch,
  output logic [7:0] err_cnt
);

  localparam int CNT_W = $clog2(PULSE_W + GUARD + 1);

  state_e           state;
  pulse_t           pulse;
  cmd_op_e          op;
  logic             model;
  logic             accept;
  logic             phase_load;
  logic             phase_expire;
  logic [CNT_W-1:0] phase_val;
  logic             read_load;
  logic             read_fire;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // One timer paces both PULSE and GUARD: loaded on a pulsing accept, reloaded as PULSE ends.
  assign phase_load = (accept && (op != OP_NOP)) || ((state == ST_PULSE) && phase_expire);
  assign phase_val  = (state == ST_PULSE) ? CNT_W'(GUARD) : CNT_W'(PULSE_W);
  assign read_load  = accept && (op == OP_READ);

  ndro_pulse_timer #(.W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (phase_load),
    .load_val (phase_val),
    .expire   (phase_expire)
  );

  // Read latency overlaps the PULSE/GUARD window, so it needs its own counter.
  ndro_pulse_timer #(.W(CNT_W)) u_read_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (read_load),
    .load_val (CNT_W'(READ_LAT)),
    .expire   (read_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pulse     <= '0;
      model     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 1'b0;
      rd_expect <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (op == OP_SET)   model <= 1'b1;
            if (op == OP_RESET) model <= 1'b0;
            if (op != OP_NOP) begin
              state <= ST_PULSE;
              pulse <= op_pulse(op);
            end
          end
        end
        ST_PULSE: begin
          if (phase_expire) begin
            state <= ST_GUARD;
            pulse <= '0;
          end
        end
        ST_GUARD: begin
          if (phase_expire) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          pulse <= '0;
        end
      endcase

      // A read never coincides with a model update: the sample lands inside its own PULSE/GUARD window.
      if (read_fire) begin
        rd_valid  <= 1'b1;
        rd_data   <= ndro_out_i;
        rd_expect <= model;
        if (ndro_out_i != model) begin
          mismatch <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  assign set_o   = pulse.set;
  assign reset_o = pulse.reset;
  assign clk_o   = pulse.clk;

endmodule

// File: tb/tb_ndro_pulse_sequencer.sv
// Bench for ndro_pulse_sequencer: directed and random commands checked cycle by cycle
// against a timestamp model (accept edge, pulse window, idle edge, read edge).
module tb_ndro_pulse_sequencer;

  localparam int PULSE_W  = 1;
  localparam int GUARD    = 4;
  localparam int READ_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       set_o, reset_o, clk_o;
  logic       ndro_out_i;
  logic       rd_valid, rd_data, rd_expect, mismatch;
  logic [7:0] err_cnt;

  ndro_pulse_sequencer #(
    .PULSE_W  (PULSE_W),
    .GUARD    (GUARD),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .set_o      (set_o),
    .reset_o    (reset_o),
    .clk_o      (clk_o),
    .ndro_out_i (ndro_out_i),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_expect  (rd_expect),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Model: cycle n is the interval after rising edge n.
  int         cyc;
  int         idle_at;
  int         p_start;
  int         read_at;
  int         err;
  logic [1:0] p_op;
  logic       mbit, mism, e_data, e_exp, accepted;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic reset_model();
    idle_at = 0;
    p_start = -100;
    read_at = -1;
    p_op    = 2'b00;
    mbit    = 1'b0;
    mism    = 1'b0;
    err     = 0;
    e_data  = 1'b0;
    e_exp   = 1'b0;
  endtask

  task automatic check_outputs();
    logic in_p;
    logic rdv;
    in_p = (cyc >= p_start) && (cyc < p_start + PULSE_W);
    rdv  = rst_n && (cyc == read_at);
    chk("cmd_ready", 8'(cmd_ready), 8'(cyc >= idle_at));
    chk("set_o",     8'(set_o),     8'(in_p && p_op == 2'b01));
    chk("reset_o",   8'(reset_o),   8'(in_p && p_op == 2'b10));
    chk("clk_o",     8'(clk_o),     8'(in_p && p_op == 2'b11));
    chk("onehot",    8'($countones({set_o, reset_o, clk_o}) <= 1), 8'd1);
    chk("rd_valid",  8'(rd_valid),  8'(rdv));
    if (rdv || !rst_n) begin
      chk("rd_data",   8'(rd_data),   8'(e_data));
      chk("rd_expect", 8'(rd_expect), 8'(e_exp));
    end
    chk("mismatch",  8'(mismatch),  8'(mism));
    chk("err_cnt",   err_cnt,       8'(err));
  endtask

  // Check this cycle, then advance the model across the next rising edge.
  task automatic tick();
    logic       acc, nd_prev, rst_prev;
    logic [1:0] op_prev;
    @(negedge clk);
    check_outputs();
    nd_prev  = ndro_out_i;
    rst_prev = rst_n;
    op_prev  = cmd_op;
    acc      = rst_n && cmd_valid && (cyc >= idle_at);
    @(posedge clk);
    cyc++;
    accepted = 1'b0;
    if (rst_prev && rst_n) begin
      if (cyc == read_at) begin
        e_data = nd_prev;
        e_exp  = mbit;
        if (nd_prev != mbit) begin
          mism = 1'b1;
          if (err < 255) err++;
        end
      end
      if (acc) begin
        accepted = 1'b1;
        if (op_prev == 2'b01) mbit = 1'b1;
        if (op_prev == 2'b10) mbit = 1'b0;
        if (op_prev != 2'b00) begin
          p_op    = op_prev;
          p_start = cyc;
          idle_at = cyc + PULSE_W + GUARD;
        end
        if (op_prev == 2'b11) read_at = cyc + READ_LAT;
      end
    end
    #1;
  endtask

  // Upstream holds the op valid until the model says it was taken.
  task automatic issue(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (accepted) break;
    end
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic read_cell(input logic nd);
    ndro_out_i = nd;
    issue(2'b11);
    repeat (READ_LAT) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    logic       rnd;

    cyc        = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    ndro_out_i = 1'b0;
    reset_model();
    #1;

    // Reset state, then release and SET on the first edge.
    repeat (3) tick();
    rst_n = 1'b1;
    issue(2'b01);
    // RESET held valid through the SET guard window.
    issue(2'b10);
    repeat (6) tick();

    // Good read after SET.
    issue(2'b01);
    read_cell(1'b1);
    // Bad read after RESET, then a correct read: mismatch and count stick.
    issue(2'b10);
    read_cell(1'b1);
    read_cell(1'b0);
    // NOP accepts without pulsing.
    issue(2'b00);
    issue(2'b00);
    repeat (2) tick();

    // Reset during the clk_o pulse of a READ.
    issue(2'b01);
    ndro_out_i = 1'b0;
    issue(2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_clk_o_drop", 8'(clk_o),    8'd0);
    chk("rst_rd_valid",   8'(rd_valid), 8'd0);
    chk("rst_err_cnt",    err_cnt,      8'd0);
    chk("rst_mismatch",   8'(mismatch), 8'd0);
    reset_model();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (READ_LAT + 3) tick();
    read_cell(1'b1);

    // Random commands with random gaps and occasional bad cell data.
    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
      rnd = ($urandom_range(0, 3) == 0) ? ~mbit : mbit;
      ndro_out_i = rnd;
      issue(rop);
      if (rop == 2'b11) repeat (READ_LAT) tick();
    end

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      read_cell(~mbit);
    end
    repeat (GUARD + 2) tick();
    chk("err_cnt_sat",  err_cnt,      8'd255);
    chk("mismatch_sat", 8'(mismatch), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
